request_manager: RTL and testbench

- Upstream stage of the car state controller for the 4-storey elevator.
- Captures car (inside) buttons and hall up/down buttons as rising-edge requests, holding each one until the car serves it.
- Clears served requests while the door is open.
- Produces allReq_reg, up_need and down_need for the state controller, plus lamp and count outputs for the display.

---
 rtl/request_manager.sv | 106 ++++++++++
 tb/tb_request_manager.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/request_manager.sv
// Request capture for the elevator car controller: edge-detects car and hall
// buttons, holds each call until served at an open door, and summarises demand.
module request_manager #(
    parameter int N_FLOORS = 4,
    parameter int CW       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  switch,
    input  logic [N_FLOORS-1:0]   in_btn,
    input  logic [N_FLOORS-2:0]   up_btn,
    input  logic [N_FLOORS-2:0]   down_btn,
    input  logic [N_FLOORS-1:0]   position,
    input  logic                  opendoor,
    input  logic [1:0]            ud_mode,
    output logic [N_FLOORS-1:0]   in_reg,
    output logic [N_FLOORS-2:0]   up_reg,
    output logic [N_FLOORS-2:0]   down_reg,
    output logic [N_FLOORS-1:0]   allReq_reg,
    output logic                  up_need,
    output logic                  down_need,
    output logic [CW-1:0]         req_cnt
);

    localparam int                  NH  = N_FLOORS - 1;
    localparam logic [N_FLOORS-1:0] ONE = 1;

    logic [N_FLOORS-1:0] in_prev_q, in_prev_d;
    logic [NH-1:0]       up_prev_q, up_prev_d;
    logic [NH-1:0]       down_prev_q, down_prev_d;
    logic [N_FLOORS-1:0] in_reg_q, in_reg_d;
    logic [NH-1:0]       up_reg_q, up_reg_d;
    logic [NH-1:0]       down_reg_q, down_reg_d;
    logic [CW-1:0]       req_cnt_q, req_cnt_d;

    logic [N_FLOORS-1:0] serve;
    logic [NH-1:0]       clr_up, clr_dn;
    logic [N_FLOORS-1:0] allreq_d, allreq_q;
    logic [N_FLOORS-1:0] below_mask, above_mask;
    logic                pos_onehot;

    always_comb begin
        in_prev_d   = in_btn;
        up_prev_d   = up_btn;
        down_prev_d = down_btn;

        serve = opendoor ? position : '0;
        // Up call i lives at floor i, down call i lives at floor i+1.
        clr_up = (ud_mode == 2'b10) ? '0 : serve[NH-1:0];
        clr_dn = (ud_mode == 2'b01) ? '0 : serve[N_FLOORS-1:1];

        // Clear is applied after set so a press at the served floor is dropped.
        in_reg_d   = (in_reg_q   | (in_btn   & ~in_prev_q))   & ~serve;
        up_reg_d   = (up_reg_q   | (up_btn   & ~up_prev_q))   & ~clr_up;
        down_reg_d = (down_reg_q | (down_btn & ~down_prev_q)) & ~clr_dn;

        if (!switch) begin
            in_reg_d   = '0;
            up_reg_d   = '0;
            down_reg_d = '0;
        end

        allreq_d  = in_reg_d | {1'b0, up_reg_d} | {down_reg_d, 1'b0};
        req_cnt_d = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            req_cnt_d = req_cnt_d + CW'(allreq_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_prev_q   <= '0;
            up_prev_q   <= '0;
            down_prev_q <= '0;
            in_reg_q    <= '0;
            up_reg_q    <= '0;
            down_reg_q  <= '0;
            req_cnt_q   <= '0;
        end else begin
            in_prev_q   <= in_prev_d;
            up_prev_q   <= up_prev_d;
            down_prev_q <= down_prev_d;
            in_reg_q    <= in_reg_d;
            up_reg_q    <= up_reg_d;
            down_reg_q  <= down_reg_d;
            req_cnt_q   <= req_cnt_d;
        end
    end

    // For a one-hot position p, p-1 covers every floor below it.
    always_comb begin
        allreq_q   = in_reg_q | {1'b0, up_reg_q} | {down_reg_q, 1'b0};
        pos_onehot = (position != '0) && ((position & (position - ONE)) == '0);
        below_mask = position - ONE;
        above_mask = ~(position | below_mask);
    end

    assign in_reg     = in_reg_q;
    assign up_reg     = up_reg_q;
    assign down_reg   = down_reg_q;
    assign allReq_reg = allreq_q;
    assign req_cnt    = req_cnt_q;
    assign up_need    = pos_onehot && |(allreq_q & above_mask);
    assign down_need  = pos_onehot && |(allreq_q & below_mask);

endmodule

// File: tb/tb_request_manager.sv
// Directed scenarios for request_manager with hand-computed expectations.
module tb_request_manager;

    logic       clk = 1'b0;
    logic       rst, switch, opendoor;
    logic [3:0] in_btn, position;
    logic [2:0] up_btn, down_btn;
    logic [1:0] ud_mode;
    logic [3:0] in_reg, allReq_reg;
    logic [2:0] up_reg, down_reg, req_cnt;
    logic       up_need, down_need;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    request_manager #(.N_FLOORS(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .switch(switch), .in_btn(in_btn), .up_btn(up_btn),
        .down_btn(down_btn), .position(position), .opendoor(opendoor), .ud_mode(ud_mode),
        .in_reg(in_reg), .up_reg(up_reg), .down_reg(down_reg), .allReq_reg(allReq_reg),
        .up_need(up_need), .down_need(down_need), .req_cnt(req_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        $display("test_reset");
        rst = 1; switch = 1; in_btn = 4'b1111; up_btn = 0; down_btn = 0;
        position = 4'b0001; opendoor = 0; ud_mode = 2'b00;
        step(); step();
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL rst_in_reg got %b exp 0000", in_reg); end
        checks++; if (allReq_reg !== 4'b0000) begin errors++; $display("FAIL rst_allreq got %b exp 0000", allReq_reg); end
        checks++; if (req_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", req_cnt); end
        checks++; if ({up_need, down_need} !== 2'b00) begin errors++; $display("FAIL rst_needs got %b exp 00", {up_need, down_need}); end
        // Release reset with the switch off: history samples the held buttons.
        rst = 0; switch = 0;
        step(); step();
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL swoff_in_reg got %b exp 0000", in_reg); end
        switch = 1;
        step(); step();
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL held_at_switch got %b exp 0000", in_reg); end
        checks++; if (req_cnt !== 3'd0) begin errors++; $display("FAIL held_cnt got %0d exp 0", req_cnt); end
        in_btn = 0; step();
        in_btn = 4'b0100; step();
        checks++; if (in_reg !== 4'b0100) begin errors++; $display("FAIL repress_in_reg got %b exp 0100", in_reg); end
        checks++; if (req_cnt !== 3'd1) begin errors++; $display("FAIL repress_cnt got %0d exp 1", req_cnt); end
        checks++; if ({up_need, down_need} !== 2'b10) begin errors++; $display("FAIL repress_needs got %b exp 10", {up_need, down_need}); end
        in_btn = 0; position = 4'b0100; opendoor = 1; step();
        opendoor = 0;
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL serve_in_reg got %b exp 0000", in_reg); end
    endtask

    task automatic test_direction();
        $display("test_direction");
        position = 4'b0001; down_btn = 3'b100; step();
        down_btn = 0;
        checks++; if (down_reg !== 3'b100) begin errors++; $display("FAIL dir_down_reg got %b exp 100", down_reg); end
        checks++; if (allReq_reg !== 4'b1000) begin errors++; $display("FAIL dir_allreq got %b exp 1000", allReq_reg); end
        checks++; if ({up_need, down_need} !== 2'b10) begin errors++; $display("FAIL dir_needs got %b exp 10", {up_need, down_need}); end
        checks++; if (req_cnt !== 3'd1) begin errors++; $display("FAIL dir_cnt got %0d exp 1", req_cnt); end
        position = 4'b1000; #1;
        checks++; if ({up_need, down_need} !== 2'b00) begin errors++; $display("FAIL top_needs got %b exp 00", {up_need, down_need}); end
        opendoor = 1; ud_mode = 2'b00; step();
        opendoor = 0;
        checks++; if (down_reg !== 3'b000) begin errors++; $display("FAIL top_clear got %b exp 000", down_reg); end
    endtask

    task automatic test_held();
        $display("test_held");
        position = 4'b0001; in_btn = 4'b0010; step();
        checks++; if (in_reg !== 4'b0010) begin errors++; $display("FAIL held_latch got %b exp 0010", in_reg); end
        step(); step();
        position = 4'b0010; opendoor = 1; step();
        opendoor = 0;
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL held_clear got %b exp 0000", in_reg); end
        repeat (15) step();
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL held_relatch got %b exp 0000", in_reg); end
        in_btn = 0; step();
        in_btn = 4'b0010; step();
        checks++; if (in_reg !== 4'b0010) begin errors++; $display("FAIL held_repress got %b exp 0010", in_reg); end
        in_btn = 0; opendoor = 1; step();
        opendoor = 0;
    endtask

    task automatic test_dir_clear();
        $display("test_dir_clear");
        position = 4'b0001; up_btn = 3'b010; down_btn = 3'b001; step();
        up_btn = 0; down_btn = 0;
        checks++; if ({up_reg, down_reg} !== 6'b010_001) begin errors++; $display("FAIL dc_setup got %b exp 010001", {up_reg, down_reg}); end
        checks++; if (req_cnt !== 3'd1) begin errors++; $display("FAIL dc_cnt got %0d exp 1", req_cnt); end
        position = 4'b0010; opendoor = 1; ud_mode = 2'b01; step();
        opendoor = 0;
        checks++; if (up_reg !== 3'b000) begin errors++; $display("FAIL dc_up_reg got %b exp 000", up_reg); end
        checks++; if (down_reg !== 3'b001) begin errors++; $display("FAIL dc_down_kept got %b exp 001", down_reg); end
        checks++; if (allReq_reg !== 4'b0010) begin errors++; $display("FAIL dc_allreq got %b exp 0010", allReq_reg); end
        up_btn = 3'b010; step();
        up_btn = 0;
        opendoor = 1; ud_mode = 2'b10; step();
        opendoor = 0;
        checks++; if ({up_reg, down_reg} !== 6'b010_000) begin errors++; $display("FAIL dc_down_mode got %b exp 010000", {up_reg, down_reg}); end
    endtask

    task automatic test_idle_clear();
        $display("test_idle_clear");
        down_btn = 3'b001; step();
        down_btn = 0;
        checks++; if ({up_reg, down_reg} !== 6'b010_001) begin errors++; $display("FAIL ic_setup got %b exp 010001", {up_reg, down_reg}); end
        opendoor = 1; ud_mode = 2'b00; in_btn = 4'b0010; step();
        opendoor = 0;
        checks++; if ({up_reg, down_reg} !== 6'b000_000) begin errors++; $display("FAIL ic_both got %b exp 000000", {up_reg, down_reg}); end
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL ic_collision got %b exp 0000", in_reg); end
        checks++; if (req_cnt !== 3'd0) begin errors++; $display("FAIL ic_cnt got %0d exp 0", req_cnt); end
        step();
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL ic_held_after got %b exp 0000", in_reg); end
        in_btn = 0;
        up_btn = 3'b010; down_btn = 3'b001; step();
        up_btn = 0; down_btn = 0;
        opendoor = 1; ud_mode = 2'b11; step();
        opendoor = 0;
        checks++; if ({up_reg, down_reg} !== 6'b000_000) begin errors++; $display("FAIL ic_reserved got %b exp 000000", {up_reg, down_reg}); end
    endtask

    task automatic test_invalid_pos();
        $display("test_invalid_pos");
        ud_mode = 2'b00; position = 4'b0010; in_btn = 4'b1001; step();
        in_btn = 0;
        checks++; if (allReq_reg !== 4'b1001) begin errors++; $display("FAIL ip_allreq got %b exp 1001", allReq_reg); end
        checks++; if (req_cnt !== 3'd2) begin errors++; $display("FAIL ip_cnt got %0d exp 2", req_cnt); end
        position = 4'b0110; #1;
        checks++; if ({up_need, down_need} !== 2'b00) begin errors++; $display("FAIL ip_multi got %b exp 00", {up_need, down_need}); end
        position = 4'b0000; #1;
        checks++; if ({up_need, down_need} !== 2'b00) begin errors++; $display("FAIL ip_zero got %b exp 00", {up_need, down_need}); end
        position = 4'b0100; #1;
        checks++; if ({up_need, down_need} !== 2'b11) begin errors++; $display("FAIL ip_both got %b exp 11", {up_need, down_need}); end
        position = 4'b0001; #1;
        checks++; if ({up_need, down_need} !== 2'b10) begin errors++; $display("FAIL ip_bottom got %b exp 10", {up_need, down_need}); end
    endtask

    task automatic test_reset_mid_door();
        $display("test_reset_mid_door");
        opendoor = 1; rst = 1; step();
        rst = 0; opendoor = 0;
        checks++; if (allReq_reg !== 4'b0000) begin errors++; $display("FAIL rmd_allreq got %b exp 0000", allReq_reg); end
        checks++; if (req_cnt !== 3'd0) begin errors++; $display("FAIL rmd_cnt got %0d exp 0", req_cnt); end
        step();
        checks++; if (allReq_reg !== 4'b0000) begin errors++; $display("FAIL rmd_after got %b exp 0000", allReq_reg); end
    endtask

    task automatic test_switch_off();
        $display("test_switch_off");
        position = 4'b1000; in_btn = 4'b0001; step();
        in_btn = 0;
        checks++; if (in_reg !== 4'b0001) begin errors++; $display("FAIL so_latch got %b exp 0001", in_reg); end
        checks++; if ({up_need, down_need} !== 2'b01) begin errors++; $display("FAIL so_needs got %b exp 01", {up_need, down_need}); end
        switch = 0; step();
        checks++; if ({in_reg, req_cnt} !== 7'b0000_000) begin errors++; $display("FAIL so_clear got %b exp 0000000", {in_reg, req_cnt}); end
        in_btn = 4'b0100; step();
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL so_press_off got %b exp 0000", in_reg); end
        switch = 1; step();
        checks++; if (in_reg !== 4'b0000) begin errors++; $display("FAIL so_held_on got %b exp 0000", in_reg); end
        in_btn = 0; step();
    endtask

    initial begin
        test_reset();
        test_direction();
        test_held();
        test_dir_clear();
        test_idle_clear();
        test_invalid_pos();
        test_reset_mid_door();
        test_switch_off();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
